// File: rtl/dcache_pkg.sv
// Shared types, geometry and address-slicing helpers for the data cache.
package dcache_pkg;

   localparam int unsigned LINE_ADDR_LEN = 3;
   localparam int unsigned SET_ADDR_LEN  = 2;
   localparam int unsigned TAG_LEN       = 30 - LINE_ADDR_LEN - SET_ADDR_LEN;
   localparam int unsigned LINE_SIZE     = 1 << LINE_ADDR_LEN;
   localparam int unsigned SET_SIZE      = 1 << SET_ADDR_LEN;
   localparam int unsigned DATA_W        = 32;

   typedef logic [TAG_LEN-1:0]       tag_t;
   typedef logic [SET_ADDR_LEN-1:0]  set_t;
   typedef logic [LINE_ADDR_LEN-1:0] word_t;

   typedef enum logic [1:0] {IDLE, SWAP_OUT, SWAP_IN, SWAP_IN_OK} state_e;

   // Per-line bookkeeping written as one unit.
   typedef struct packed {
      tag_t tag;
      logic valid;
      logic dirty;
   } line_meta_t;

   function automatic tag_t get_tag(input logic [31:0] addr);
      return addr[31 -: TAG_LEN];
   endfunction

   function automatic set_t get_set(input logic [31:0] addr);
      return addr[2 + LINE_ADDR_LEN +: SET_ADDR_LEN];
   endfunction

   function automatic word_t get_word(input logic [31:0] addr);
      return addr[2 +: LINE_ADDR_LEN];
   endfunction

endpackage

// File: rtl/data_cache_if.sv
// Pipeline-side request bus plus word-serial memory handshake of the data cache.
interface data_cache_if;
   logic        rd_req;
   logic        wr_req;
   logic [31:0] addr;
   logic [31:0] wr_data;
   logic [31:0] rd_data;
   logic        miss;
   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic        mem_gnt;
   logic [31:0] mem_rdata;
   logic [31:0] miss_cnt;

   modport slave (
      input  rd_req, wr_req, addr, wr_data, mem_gnt, mem_rdata,
      output rd_data, miss, mem_req, mem_we, mem_addr, mem_wdata, miss_cnt
   );

   modport master (
      output rd_req, wr_req, addr, wr_data, mem_gnt, mem_rdata,
      input  rd_data, miss, mem_req, mem_we, mem_addr, mem_wdata, miss_cnt
   );
endinterface

// File: rtl/dcache_line_array.sv
// Tag/valid/dirty/data storage: one combinational read port, one synchronous write port.
module dcache_line_array
   import dcache_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  set_t              set,
   input  word_t             rd_word,
   output line_meta_t        rd_meta,
   output logic [DATA_W-1:0] rd_data,
   input  logic              data_we,
   input  word_t             wr_word,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              meta_we,
   input  line_meta_t        wr_meta
);

   logic [DATA_W-1:0]   data_q [SET_SIZE][LINE_SIZE];
   logic [DATA_W-1:0]   data_d [SET_SIZE][LINE_SIZE];
   tag_t                tag_q  [SET_SIZE];
   tag_t                tag_d  [SET_SIZE];
   logic [SET_SIZE-1:0] valid_q, valid_d;
   logic [SET_SIZE-1:0] dirty_q, dirty_d;

   assign rd_meta = '{tag: tag_q[set], valid: valid_q[set], dirty: dirty_q[set]};
   assign rd_data = data_q[set][rd_word];

   // Apply the single word write and/or metadata update to the addressed set.
   always_comb begin
      data_d  = data_q;
      tag_d   = tag_q;
      valid_d = valid_q;
      dirty_d = dirty_q;
      if (data_we) data_d[set][wr_word] = wr_data;
      if (meta_we) begin
         tag_d[set]   = wr_meta.tag;
         valid_d[set] = wr_meta.valid;
         dirty_d[set] = wr_meta.dirty;
      end
   end

   // Tag and data contents are meaningless until valid, so they carry no reset.
   always_ff @(posedge clk) begin
      data_q <= data_d;
      tag_q  <= tag_d;
   end

   // Valid/dirty flags clear on reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q <= '0;
         dirty_q <= '0;
      end else begin
         valid_q <= valid_d;
         dirty_q <= dirty_d;
      end
   end

endmodule

// File: rtl/data_cache.sv
// Direct-mapped write-back, write-allocate data cache with word-serial refill/writeback.
module data_cache
   import dcache_pkg::*;
(
   input  logic clk,
   input  logic rst,
   data_cache_if.slave bus
);

   state_e            state_q, state_d;
   word_t             cnt_q, cnt_d;
   logic [31:0]       miss_cnt_q, miss_cnt_d;

   tag_t              req_tag;
   set_t              req_set;
   word_t             req_word;
   logic              req, hit;
   line_meta_t        meta, wr_meta;
   logic [DATA_W-1:0] line_rdata, wr_data;
   word_t             rd_word, wr_word;
   logic              data_we, meta_we;

   assign req_tag  = get_tag(bus.addr);
   assign req_set  = get_set(bus.addr);
   assign req_word = get_word(bus.addr);
   assign req      = bus.rd_req | bus.wr_req;
   assign hit      = req && meta.valid && (meta.tag == req_tag);
   // Writeback streams the victim line out through the shared read port.
   assign rd_word      = (state_q == SWAP_OUT) ? cnt_q : req_word;
   assign bus.miss_cnt = miss_cnt_q;

   dcache_line_array u_lines (
      .clk     (clk),
      .rst     (rst),
      .set     (req_set),
      .rd_word (rd_word),
      .rd_meta (meta),
      .rd_data (line_rdata),
      .data_we (data_we),
      .wr_word (wr_word),
      .wr_data (wr_data),
      .meta_we (meta_we),
      .wr_meta (wr_meta)
   );

   // Next state, hit service and memory handshake.
   always_comb begin
      state_d       = state_q;
      cnt_d         = cnt_q;
      miss_cnt_d    = miss_cnt_q;
      data_we       = 1'b0;
      wr_word       = req_word;
      wr_data       = bus.wr_data;
      meta_we       = 1'b0;
      wr_meta       = meta;
      bus.rd_data   = '0;
      bus.miss      = 1'b0;
      bus.mem_req   = 1'b0;
      bus.mem_we    = 1'b0;
      bus.mem_addr  = '0;
      bus.mem_wdata = '0;
      unique case (state_q)
         IDLE: begin
            if (req && hit) begin
               if (bus.wr_req) begin
                  data_we       = 1'b1;
                  meta_we       = 1'b1;
                  wr_meta.dirty = 1'b1;
               end else begin
                  bus.rd_data = line_rdata;
               end
            end else if (req) begin
               // Invalidate up front so an abandoned refill never leaves a half line valid.
               bus.miss      = 1'b1;
               miss_cnt_d    = miss_cnt_q + 32'd1;
               cnt_d         = '0;
               meta_we       = 1'b1;
               wr_meta.valid = 1'b0;
               wr_meta.dirty = 1'b0;
               state_d       = (meta.valid && meta.dirty) ? SWAP_OUT : SWAP_IN;
            end
         end
         SWAP_OUT: begin
            bus.miss      = 1'b1;
            bus.mem_req   = 1'b1;
            bus.mem_we    = 1'b1;
            bus.mem_addr  = {meta.tag, req_set, cnt_q, 2'b00};
            bus.mem_wdata = line_rdata;
            if (bus.mem_gnt) begin
               cnt_d = cnt_q + LINE_ADDR_LEN'(1);
               if (&cnt_q) state_d = SWAP_IN;
            end
         end
         SWAP_IN: begin
            bus.miss     = 1'b1;
            bus.mem_req  = 1'b1;
            bus.mem_addr = {req_tag, req_set, cnt_q, 2'b00};
            if (bus.mem_gnt) begin
               data_we = 1'b1;
               wr_word = cnt_q;
               wr_data = bus.mem_rdata;
               cnt_d   = cnt_q + LINE_ADDR_LEN'(1);
               if (&cnt_q) state_d = SWAP_IN_OK;
            end
         end
         SWAP_IN_OK: begin
            bus.miss = 1'b1;
            meta_we  = 1'b1;
            wr_meta  = '{tag: req_tag, valid: 1'b1, dirty: 1'b0};
            state_d  = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // State, word counter and miss counter registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         miss_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         miss_cnt_q <= miss_cnt_d;
      end
   end

endmodule

// File: tb/tb_data_cache.sv
// Directed self-checking bench for data_cache with a behavioural word memory.
module tb_data_cache;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   data_cache_if bus ();

   data_cache dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   typedef struct {
      logic [31:0] a;
      logic [31:0] d;
   } wr_t;

   int          n_cmp = 0;
   int          n_err = 0;
   int          gnt_delay = 0;
   int          wait_cnt = 0;
   wr_t         wr_log[$];
   logic [31:0] rd_log[$];
   logic [31:0] store [logic [31:0]];

   // Backing memory: untouched word at byte address a holds 0x1000 + a/4.
   function automatic logic [31:0] mem_model(input logic [31:0] a);
      if (store.exists(a)) return store[a];
      return 32'h1000 + (a >> 2);
   endfunction

   // Responder: decide grant for the coming edge once DUT outputs have settled.
   always begin
      @(negedge clk);
      #1;
      bus.mem_gnt   = bus.mem_req && (wait_cnt >= gnt_delay);
      bus.mem_rdata = mem_model(bus.mem_addr);
   end

   // Log completed transactions and count wait cycles.
   always @(posedge clk) begin
      if (bus.mem_req && bus.mem_gnt) begin
         if (bus.mem_we) begin
            wr_log.push_back('{a: bus.mem_addr, d: bus.mem_wdata});
            store[bus.mem_addr] = bus.mem_wdata;
         end else begin
            rd_log.push_back(bus.mem_addr);
         end
         wait_cnt = 0;
      end else if (bus.mem_req) begin
         wait_cnt = wait_cnt + 1;
      end else begin
         wait_cnt = 0;
      end
   end

   // Drive a request at a falling edge and count cycles until miss drops.
   task automatic do_access(input logic rd, input logic wr, input logic [31:0] a,
                            input logic [31:0] d, output int cycles);
      @(negedge clk);
      bus.rd_req  = rd;
      bus.wr_req  = wr;
      bus.addr    = a;
      bus.wr_data = d;
      #2;
      cycles = 0;
      while (bus.miss === 1'b1 && cycles < 500) begin
         cycles++;
         @(negedge clk);
         #2;
      end
   endtask

   task automatic release_req();
      @(negedge clk);
      bus.rd_req = 1'b0;
      bus.wr_req = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      #2;
      n_cmp++; if (bus.miss !== 1'b0) begin n_err++; $display("FAIL reset_miss got=%b want=0", bus.miss); end
      n_cmp++; if (bus.mem_req !== 1'b0) begin n_err++; $display("FAIL reset_mem_req got=%b want=0", bus.mem_req); end
      n_cmp++; if (bus.mem_we !== 1'b0) begin n_err++; $display("FAIL reset_mem_we got=%b want=0", bus.mem_we); end
      n_cmp++; if (bus.miss_cnt !== 32'd0) begin n_err++; $display("FAIL reset_miss_cnt got=%0d want=0", bus.miss_cnt); end
   endtask

   task automatic test_clean_miss();
      int cyc;
      rd_log.delete();
      do_access(1'b1, 1'b0, 32'h40, 32'h0, cyc);
      n_cmp++; if (cyc !== 10) begin n_err++; $display("FAIL clean_miss_cycles got=%0d want=10", cyc); end
      n_cmp++; if (bus.rd_data !== 32'h1010) begin n_err++; $display("FAIL clean_miss_rd_data got=%h want=00001010", bus.rd_data); end
      n_cmp++; if (bus.miss_cnt !== 32'd1) begin n_err++; $display("FAIL clean_miss_cnt got=%0d want=1", bus.miss_cnt); end
      n_cmp++; if (rd_log.size() !== 8) begin n_err++; $display("FAIL clean_miss_reads got=%0d want=8", rd_log.size()); end
      n_cmp++; if (rd_log.size() == 0 || rd_log[0] !== 32'h40) begin n_err++; $display("FAIL clean_miss_first_addr got=%h want=00000040", (rd_log.size() == 0) ? 32'hx : rd_log[0]); end
   endtask

   task automatic test_read_hit();
      @(negedge clk);
      bus.rd_req = 1'b1;
      bus.addr   = 32'h44;
      #2;
      n_cmp++; if (bus.miss !== 1'b0) begin n_err++; $display("FAIL hit_miss got=%b want=0", bus.miss); end
      n_cmp++; if (bus.rd_data !== 32'h1011) begin n_err++; $display("FAIL hit_rd_data got=%h want=00001011", bus.rd_data); end
      n_cmp++; if (bus.miss_cnt !== 32'd1) begin n_err++; $display("FAIL hit_miss_cnt got=%0d want=1", bus.miss_cnt); end
      release_req();
   endtask

   task automatic test_dirty_evict();
      int cyc;
      do_access(1'b0, 1'b1, 32'h40, 32'hDEAD_BEEF, cyc);
      n_cmp++; if (cyc !== 0) begin n_err++; $display("FAIL wr_hit_cycles got=%0d want=0", cyc); end
      release_req();
      wr_log.delete();
      rd_log.delete();
      do_access(1'b1, 1'b0, 32'h240, 32'h0, cyc);
      n_cmp++; if (cyc !== 18) begin n_err++; $display("FAIL dirty_miss_cycles got=%0d want=18", cyc); end
      n_cmp++; if (wr_log.size() !== 8) begin n_err++; $display("FAIL wb_count got=%0d want=8", wr_log.size()); end
      if (wr_log.size() == 8) begin
         n_cmp++; if (wr_log[0].a !== 32'h40 || wr_log[0].d !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL wb_word0 got=%h:%h want=00000040:deadbeef", wr_log[0].a, wr_log[0].d); end
         n_cmp++; if (wr_log[7].a !== 32'h5C || wr_log[7].d !== 32'h1017) begin n_err++; $display("FAIL wb_word7 got=%h:%h want=0000005c:00001017", wr_log[7].a, wr_log[7].d); end
      end
      n_cmp++; if (rd_log.size() == 0 || rd_log[0] !== 32'h240) begin n_err++; $display("FAIL refill_first_addr got=%h want=00000240", (rd_log.size() == 0) ? 32'hx : rd_log[0]); end
      n_cmp++; if (bus.rd_data !== 32'h1090) begin n_err++; $display("FAIL dirty_miss_rd_data got=%h want=00001090", bus.rd_data); end
      n_cmp++; if (bus.miss_cnt !== 32'd2) begin n_err++; $display("FAIL dirty_miss_cnt got=%0d want=2", bus.miss_cnt); end
      release_req();
   endtask

   task automatic test_gnt_delay();
      int cyc;
      int held;
      int stab_err;
      logic pend;
      logic [31:0] p_addr, p_wd;
      logic p_we;
      do_access(1'b0, 1'b1, 32'h244, 32'hCAFE_0001, cyc);
      release_req();
      wr_log.delete();
      gnt_delay = 3;
      @(negedge clk);
      bus.rd_req = 1'b1;
      bus.addr   = 32'h40;
      #2;
      cyc = 0; held = 0; stab_err = 0; pend = 1'b0;
      p_addr = '0; p_wd = '0; p_we = 1'b0;
      while (bus.miss === 1'b1 && cyc < 500) begin
         if (pend) begin
            held++;
            if (bus.mem_addr !== p_addr || bus.mem_wdata !== p_wd || bus.mem_we !== p_we) stab_err++;
         end
         pend   = bus.mem_req && !bus.mem_gnt;
         p_addr = bus.mem_addr;
         p_wd   = bus.mem_wdata;
         p_we   = bus.mem_we;
         cyc++;
         @(negedge clk);
         #2;
      end
      n_cmp++; if (cyc !== 66) begin n_err++; $display("FAIL slow_miss_cycles got=%0d want=66", cyc); end
      n_cmp++; if (held !== 48) begin n_err++; $display("FAIL slow_wait_cycles got=%0d want=48", held); end
      n_cmp++; if (stab_err !== 0) begin n_err++; $display("FAIL slow_stability got=%0d want=0", stab_err); end
      n_cmp++; if (bus.mem_req !== 1'b0) begin n_err++; $display("FAIL slow_mem_req_after got=%b want=0", bus.mem_req); end
      n_cmp++; if (bus.rd_data !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL slow_rd_data got=%h want=deadbeef", bus.rd_data); end
      n_cmp++; if (wr_log.size() < 2 || wr_log[1].a !== 32'h244 || wr_log[1].d !== 32'hCAFE_0001) begin n_err++; $display("FAIL slow_wb_word1 got=%h want=cafe0001", (wr_log.size() < 2) ? 32'hx : wr_log[1].d); end
      n_cmp++; if (bus.miss_cnt !== 32'd3) begin n_err++; $display("FAIL slow_miss_cnt got=%0d want=3", bus.miss_cnt); end
      gnt_delay = 0;
      release_req();
   endtask

   task automatic test_reset_mid_refill();
      int cyc;
      @(negedge clk);
      bus.rd_req = 1'b1;
      bus.addr   = 32'h400;
      #2;
      n_cmp++; if (bus.miss !== 1'b1) begin n_err++; $display("FAIL rst_mid_first_miss got=%b want=1", bus.miss); end
      repeat (4) @(negedge clk);
      #2;
      n_cmp++; if (bus.mem_req !== 1'b1) begin n_err++; $display("FAIL rst_mid_req_before got=%b want=1", bus.mem_req); end
      rst        = 1'b1;
      bus.rd_req = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      #2;
      n_cmp++; if (bus.mem_req !== 1'b0) begin n_err++; $display("FAIL rst_mid_mem_req got=%b want=0", bus.mem_req); end
      n_cmp++; if (bus.miss !== 1'b0) begin n_err++; $display("FAIL rst_mid_miss got=%b want=0", bus.miss); end
      n_cmp++; if (bus.miss_cnt !== 32'd0) begin n_err++; $display("FAIL rst_mid_cnt got=%0d want=0", bus.miss_cnt); end
      do_access(1'b1, 1'b0, 32'h400, 32'h0, cyc);
      n_cmp++; if (cyc !== 10) begin n_err++; $display("FAIL rst_retry_cycles got=%0d want=10", cyc); end
      n_cmp++; if (bus.rd_data !== 32'h1100) begin n_err++; $display("FAIL rst_retry_rd_data got=%h want=00001100", bus.rd_data); end
      n_cmp++; if (bus.miss_cnt !== 32'd1) begin n_err++; $display("FAIL rst_retry_cnt got=%0d want=1", bus.miss_cnt); end
      release_req();
   endtask

   task automatic test_rd_wr_together();
      int cyc;
      do_access(1'b1, 1'b1, 32'h408, 32'h5555_AAAA, cyc);
      n_cmp++; if (cyc !== 0) begin n_err++; $display("FAIL rdwr_cycles got=%0d want=0", cyc); end
      release_req();
      do_access(1'b1, 1'b0, 32'h408, 32'h0, cyc);
      n_cmp++; if (cyc !== 0 || bus.rd_data !== 32'h5555_AAAA) begin n_err++; $display("FAIL rdwr_readback got=%h/%0d want=5555aaaa/0", bus.rd_data, cyc); end
      release_req();
      wr_log.delete();
      do_access(1'b1, 1'b0, 32'h600, 32'h0, cyc);
      n_cmp++; if (cyc !== 18) begin n_err++; $display("FAIL rdwr_evict_cycles got=%0d want=18", cyc); end
      n_cmp++; if (wr_log.size() < 3 || wr_log[2].a !== 32'h408 || wr_log[2].d !== 32'h5555_AAAA) begin n_err++; $display("FAIL rdwr_wb_word2 got=%h want=5555aaaa", (wr_log.size() < 3) ? 32'hx : wr_log[2].d); end
      n_cmp++; if (bus.rd_data !== 32'h1180) begin n_err++; $display("FAIL rdwr_evict_rd_data got=%h want=00001180", bus.rd_data); end
      release_req();
      #2;
      n_cmp++; if (bus.miss !== 1'b0 || bus.mem_req !== 1'b0) begin n_err++; $display("FAIL no_req_idle got=%b/%b want=0/0", bus.miss, bus.mem_req); end
      n_cmp++; if (bus.miss_cnt !== 32'd2) begin n_err++; $display("FAIL final_miss_cnt got=%0d want=2", bus.miss_cnt); end
   endtask

   initial begin
      bus.rd_req    = 1'b0;
      bus.wr_req    = 1'b0;
      bus.addr      = '0;
      bus.wr_data   = '0;
      bus.mem_gnt   = 1'b0;
      bus.mem_rdata = '0;
      test_reset();
      test_clean_miss();
      test_read_hit();
      test_dirty_evict();
      test_gnt_delay();
      test_reset_mid_refill();
      test_rd_wr_together();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
